// File: rtl/mem_responder.sv
// Unified instruction/data RAM with a small MMIO control window (TOHOST/halt and counters).
// Reads are combinational; stores and all control state update on the rising clock edge.
module mem_responder #(
    parameter int unsigned WORD_BITWIDTH = 32,
    parameter int unsigned DEPTH_BITS    = 12,
    parameter logic [15:0] MMIO_TAG      = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_BITWIDTH-1:0] inst_addr_i,
    input  logic                     inst_ce_i,
    output logic [WORD_BITWIDTH-1:0] inst_o,
    input  logic                     data_ce_i,
    input  logic                     data_we_i,
    input  logic [WORD_BITWIDTH-1:0] data_addr_i,
    input  logic [WORD_BITWIDTH-1:0] data_i,
    output logic [WORD_BITWIDTH-1:0] data_o,
    output logic                     halt_o,
    output logic [WORD_BITWIDTH-1:0] tohost_o,
    output logic                     misalign_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam logic [WORD_BITWIDTH-1:0] NOP = WORD_BITWIDTH'(32'h0000_0013);
    localparam logic [15:0] OFF_TOHOST = 16'h0000;
    localparam logic [15:0] OFF_CYCLE  = 16'h0004;
    localparam logic [15:0] OFF_STORES = 16'h0008;
    localparam logic [15:0] OFF_LOADS  = 16'h000C;

    typedef struct packed {
        logic                  ld;
        logic                  st;
        logic                  mis;
        logic                  mmio;
        logic [15:0]           off;
        logic [DEPTH_BITS-1:0] idx;
    } dreq_t;

    logic [WORD_BITWIDTH-1:0] ram_q [DEPTH];
    logic [WORD_BITWIDTH-1:0] cycle_q, cycle_d;
    logic [WORD_BITWIDTH-1:0] stores_q, stores_d;
    logic [WORD_BITWIDTH-1:0] loads_q, loads_d;
    logic [WORD_BITWIDTH-1:0] tohost_q, tohost_d;
    logic                     halt_q, halt_d;
    logic                     misalign_q, misalign_d;

    dreq_t                    dreq;
    logic                     ram_we;
    logic                     ram_ld;
    logic                     tohost_we;
    logic [WORD_BITWIDTH-1:0] mmio_rdata;
    logic                     unused_inst_bits;

    // Fetch ignores the byte offset and everything above the RAM index.
    assign unused_inst_bits = ^{inst_addr_i[WORD_BITWIDTH-1:DEPTH_BITS+2], inst_addr_i[1:0]};

    // Misalignment is resolved before MMIO decode, so a misaligned MMIO store never lands.
    always_comb begin
        dreq      = '0;
        dreq.mis  = data_ce_i & (data_addr_i[1:0] != 2'b00);
        dreq.mmio = (data_addr_i[31:16] == MMIO_TAG);
        dreq.off  = data_addr_i[15:0];
        dreq.idx  = data_addr_i[DEPTH_BITS+1:2];
        dreq.ld   = data_ce_i & ~data_we_i & ~dreq.mis;
        dreq.st   = data_ce_i & data_we_i & ~dreq.mis & ~halt_q & ~rst;
    end

    assign ram_we    = dreq.st & ~dreq.mmio;
    assign ram_ld    = dreq.ld & ~dreq.mmio;
    assign tohost_we = dreq.st & dreq.mmio & (dreq.off == OFF_TOHOST);

    always_comb begin
        cycle_d    = cycle_q;
        stores_d   = stores_q;
        loads_d    = loads_q;
        tohost_d   = tohost_q;
        halt_d     = halt_q;
        misalign_d = misalign_q | dreq.mis;
        if (!halt_q) begin
            cycle_d = cycle_q + WORD_BITWIDTH'(1);
            if (ram_ld) loads_d = loads_q + WORD_BITWIDTH'(1);
        end
        if (ram_we) stores_d = stores_q + WORD_BITWIDTH'(1);
        if (tohost_we) begin
            tohost_d = data_i;
            if (data_i != '0) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q    <= '0;
            stores_q   <= '0;
            loads_q    <= '0;
            tohost_q   <= '0;
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            stores_q   <= stores_d;
            loads_q    <= loads_d;
            tohost_q   <= tohost_d;
            halt_q     <= halt_d;
            misalign_q <= misalign_d;
        end
    end

    // RAM has no reset; ram_we already excludes reset and halt.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[dreq.idx] <= data_i;
    end

    always_comb begin
        unique case (dreq.off)
            OFF_TOHOST: mmio_rdata = tohost_q;
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_STORES: mmio_rdata = stores_q;
            OFF_LOADS:  mmio_rdata = loads_q;
            default:    mmio_rdata = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        if (dreq.ld) data_o = dreq.mmio ? mmio_rdata : ram_q[dreq.idx];
    end

    assign inst_o     = inst_ce_i ? ram_q[inst_addr_i[DEPTH_BITS+1:2]] : NOP;
    assign halt_o     = halt_q;
    assign tohost_o   = tohost_q;
    assign misalign_o = misalign_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected load data is queued as stimulus is driven
// and popped when the combinational response is sampled.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_ce;
    logic [31:0] inst_o;
    logic        data_ce;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        halt_o;
    logic [31:0] tohost_o;
    logic        misalign_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cyc_m;
    logic        halt_m;

    localparam logic [31:0] A_TOHOST = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] A_STORES = 32'hFFFF_0008;
    localparam logic [31:0] A_LOADS  = 32'hFFFF_000C;

    mem_responder dut (
        .clk(clk), .rst(rst),
        .inst_addr_i(inst_addr), .inst_ce_i(inst_ce), .inst_o(inst_o),
        .data_ce_i(data_ce), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_i(wdata), .data_o(data_o),
        .halt_o(halt_o), .tohost_o(tohost_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    // Reference for the free-running cycle counter and the halt flag.
    always @(posedge clk) begin
        if (rst) begin
            cyc_m  <= 32'd0;
            halt_m <= 1'b0;
        end else begin
            if (!halt_m) cyc_m <= cyc_m + 32'd1;
            if (!halt_m && data_ce && data_we && data_addr == A_TOHOST && wdata != 32'd0)
                halt_m <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d);
        data_ce = ce; data_we = we; data_addr = a; wdata = d;
    endtask

    // Drives one load per cycle for each queued address, checking against the scoreboard.
    task automatic run_loads(input logic [31:0] addrs[$], input string nm);
        logic [31:0] e;
        foreach (addrs[i]) begin
            drv(1'b1, 1'b0, addrs[i], 32'd0);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_o !== e) begin
                n_fail++;
                $display("FAIL %s[%0d] addr=%h: data_o=%h expected %h", nm, i, addrs[i], data_o, e);
            end
            tick;
        end
        drv(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        logic [31:0] aq[$];
        rst = 1'b1; inst_ce = 1'b0; inst_addr = 32'd0;
        drv(1'b0, 1'b0, 32'd0, 32'd0);
        tick; tick;
        n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b expected 0", halt_o); end
        n_checks++; if (tohost_o !== 32'd0) begin n_fail++; $display("FAIL reset_tohost: got %h expected 0", tohost_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
        rst = 1'b0;
        // First post-reset cycle reads 0, tenth reads 9.
        aq = {A_CYCLE}; exp_q.push_back(32'd0); run_loads(aq, "cycle_first");
        repeat (8) tick;
        aq = {A_CYCLE, A_STORES, A_LOADS};
        exp_q.push_back(32'd9); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        run_loads(aq, "reset_counters");
    endtask

    task automatic test_fetch;
        logic [31:0] aq[$];
        inst_ce = 1'b0; inst_addr = 32'h0C; #1;
        n_checks++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_nop: got %h expected 00000013", inst_o); end
        drv(1'b1, 1'b1, 32'h0C, 32'h00A0_0093); tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0);
        inst_ce = 1'b1; inst_addr = 32'h0C; #1;
        n_checks++; if (inst_o !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_word: got %h expected 00a00093", inst_o); end
        inst_addr = 32'h0F; #1;
        n_checks++; if (inst_o !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_lowbits: got %h expected 00a00093", inst_o); end
        inst_addr = 32'hFFFF_000C; #1;
        n_checks++; if (inst_o !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_no_mmio: got %h expected 00a00093", inst_o); end
        drv(1'b1, 1'b1, 32'h0000_400C, 32'h1111_1111); tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0);
        inst_addr = 32'h0C; #1;
        n_checks++; if (inst_o !== 32'h1111_1111) begin n_fail++; $display("FAIL fetch_alias: got %h expected 11111111", inst_o); end
        inst_ce = 1'b0;
        aq = {32'h0C}; exp_q.push_back(32'h1111_1111); run_loads(aq, "load_alias");
    endtask

    task automatic test_store_load;
        logic [31:0] aq[$];
        drv(1'b1, 1'b1, 32'h100, 32'h1234_5678); tick;
        drv(1'b1, 1'b1, 32'h200, 32'hA5A5_A5A5); tick;
        drv(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        inst_ce = 1'b1; inst_addr = 32'h100; #1;
        n_checks++; if (inst_o !== 32'h1234_5678) begin n_fail++; $display("FAIL same_cycle_old: got %h expected 12345678", inst_o); end
        tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0); #1;
        n_checks++; if (inst_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch_after_store: got %h expected deadbeef", inst_o); end
        inst_ce = 1'b0;
        aq = {32'h100, 32'h200, 32'h100, A_STORES, A_LOADS};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'd5); exp_q.push_back(32'd4);
        run_loads(aq, "store_load");
    endtask

    task automatic test_misalign;
        logic [31:0] aq[$];
        drv(1'b1, 1'b1, 32'h102, 32'hBAD0_BAD0); #1;
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_early: got %b expected 0", misalign_o); end
        tick;
        drv(1'b1, 1'b1, 32'hFFFF_0002, 32'd5); #1;
        n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b expected 1", misalign_o); end
        tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0); #1;
        n_checks++; if (tohost_o !== 32'd0 || halt_o !== 1'b0) begin
            n_fail++; $display("FAIL misalign_mmio_store: tohost=%h halt=%b expected 0/0", tohost_o, halt_o);
        end
        aq = {32'h100, 32'h101, A_LOADS, A_STORES};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'd0); exp_q.push_back(32'd5); exp_q.push_back(32'd5);
        run_loads(aq, "misalign");
        n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b expected 1", misalign_o); end
    endtask

    task automatic test_mmio;
        logic [31:0] aq[$];
        drv(1'b1, 1'b1, A_STORES, 32'd99); tick;
        drv(1'b1, 1'b1, A_TOHOST, 32'd0); tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0); #1;
        n_checks++; if (tohost_o !== 32'd0 || halt_o !== 1'b0) begin
            n_fail++; $display("FAIL tohost_zero: tohost=%h halt=%b expected 0/0", tohost_o, halt_o);
        end
        aq = {32'hFFFF_0010, A_STORES};
        exp_q.push_back(32'd0); exp_q.push_back(32'd5);
        run_loads(aq, "mmio_ro");
        drv(1'b1, 1'b1, A_TOHOST, 32'd7); #1;
        n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", halt_o); end
        tick;
        drv(1'b0, 1'b0, 32'd0, 32'd0); #1;
        n_checks++; if (tohost_o !== 32'd7 || halt_o !== 1'b1) begin
            n_fail++; $display("FAIL tohost_seven: tohost=%h halt=%b expected 7/1", tohost_o, halt_o);
        end
        aq = {A_TOHOST}; exp_q.push_back(32'd7); run_loads(aq, "tohost_read");
    endtask

    task automatic test_halt;
        logic [31:0] aq[$];
        logic [31:0] c0;
        drv(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D); tick;
        drv(1'b1, 1'b1, A_TOHOST, 32'd0); tick;
        c0 = cyc_m;
        aq = {32'h100, A_CYCLE, A_CYCLE, A_LOADS, A_STORES};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(c0); exp_q.push_back(c0);
        exp_q.push_back(32'd5); exp_q.push_back(32'd5);
        run_loads(aq, "post_halt");
        n_checks++; if (tohost_o !== 32'd7 || halt_o !== 1'b1) begin
            n_fail++; $display("FAIL halt_frozen: tohost=%h halt=%b expected 7/1", tohost_o, halt_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] aq[$];
        drv(1'b1, 1'b1, 32'h200, 32'h5555_5555);
        rst = 1'b1; tick;
        rst = 1'b0;
        drv(1'b0, 1'b0, 32'd0, 32'd0); #1;
        n_checks++; if (halt_o !== 1'b0 || tohost_o !== 32'd0 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flags: halt=%b tohost=%h misalign=%b expected 0/0/0", halt_o, tohost_o, misalign_o);
        end
        aq = {A_STORES, A_LOADS, 32'h100, 32'h200, A_LOADS, A_CYCLE};
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hA5A5_A5A5); exp_q.push_back(32'd2); exp_q.push_back(32'd5);
        run_loads(aq, "midreset");
    endtask

    task automatic test_back_to_back;
        logic [31:0] aq[$];
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            drv(1'b1, 1'b1, 32'h300 + 32'(4 * i), v);
            exp_q.push_back(v);
            aq.push_back(32'h300 + 32'(4 * i));
            tick;
        end
        aq.push_back(A_STORES); exp_q.push_back(32'd4);
        aq.push_back(A_LOADS);  exp_q.push_back(32'd6);
        aq.push_back(A_CYCLE);  exp_q.push_back(cyc_m + 32'd6);
        run_loads(aq, "back_to_back");
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_load;
        test_misalign;
        test_mmio;
        test_halt;
        test_reset_mid;
        test_back_to_back;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the pipelined RISC-V core: serves the core's instruction-fetch port and data port from one unified word-addressed RAM, with a small memory-mapped control window (TOHOST/halt, cycle counter, load and store counters). It sits at the top level opposite the core. Core outputs connect to its `*_i` ports; its `inst_o` and `data_o` drive the core's instruction and load-data inputs. Reads are zero-latency. Writes commit at the clock edge.

## Interface
- `WORD_BITWIDTH`, 32: data and address width.
- `DEPTH_BITS`, 12: log2 of RAM depth in words (4096 words, 16 KiB).
- `MMIO_TAG`, 16'hFFFF: value of `addr[31:16]` that selects the MMIO window.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous reset, active-high.
- `inst_addr_i`, input, 32: fetch byte address.
- `inst_ce_i`, input, 1: fetch enable.
- `inst_o`, output, 32: fetched word.
- `data_ce_i`, input, 1: data access enable.
- `data_we_i`, input, 1: 1 = store, 0 = load; qualified by `data_ce_i`.
- `data_addr_i`, input, 32: data byte address.
- `data_i`, input, 32: store data.
- `data_o`, output, 32: load data.
- `halt_o`, output, 1: sticky; set by a nonzero TOHOST write.
- `tohost_o`, output, 32: last TOHOST value.
- `misalign_o`, output, 1: sticky; set by any enabled data access with `addr[1:0] != 0`.

## Operation
- RAM index is `addr[DEPTH_BITS+1:2]`. Higher address bits are ignored for RAM (aliasing), except that a data address with `addr[31:16] == MMIO_TAG` selects MMIO.
- Fetch:
  - `inst_ce_i = 1`: `inst_o` = `ram[idx]`.
  - `inst_ce_i = 0`: `inst_o` = 32'h00000013 (NOP).
  - Fetch never touches MMIO. Fetch `addr[1:0]` is ignored.
- Load (`data_ce_i & ~data_we_i`):
  - `data_o` = `ram[idx]` or the MMIO register value.
  - `data_o` = 0 when `data_ce_i = 0`, when misaligned, or for an unmapped MMIO offset.
- Store (`data_ce_i & data_we_i`): writes `data_i` at the rising edge. Full-word stores only.
- A store is suppressed when any of these hold: misaligned, `halt_o = 1`, or `rst = 1`.
- MMIO offsets (`addr[15:0]`):
  - 0x0000 TOHOST: read/write. A write latches `tohost_o`. If the written value is nonzero, `halt_o` goes to 1 from the next cycle.
  - 0x0004 CYCLE: read-only.
  - 0x0008 STORES: read-only.
  - 0x000C LOADS: read-only.
  - Writes to read-only or unmapped offsets are ignored.
- Counters are 32-bit and wrap modulo 2^32.
  - CYCLE increments every non-reset cycle while `halt_o = 0`.
  - STORES increments on each committed RAM store.
  - LOADS increments on each aligned RAM load, and only while `halt_o = 0`.
  - MMIO accesses are not counted.
- After halt: RAM and all MMIO registers are frozen and all stores are dropped. Reads (fetch, RAM, MMIO) continue normally.
- Precedence:
  - Misalignment is checked before MMIO decode: a misaligned MMIO store is dropped and sets `misalign_o`.
  - A TOHOST write of 0 updates `tohost_o` without halting.

## Timing
- Reads are combinational: same-cycle response, no handshake, no stall.
- A store is visible to loads and fetches from the cycle after its edge. A same-cycle load or fetch of that word returns the old value.
- CYCLE reads return the pre-increment value. After the first post-reset cycle, CYCLE reads 0; it increments each cycle after that.
- Reset values: `halt_o` = 0, `tohost_o` = 0, `misalign_o` = 0, CYCLE/STORES/LOADS = 0.
- RAM contents are not affected by reset. A store presented during a reset cycle is dropped.
- Reset asserted mid-run, including after halt, clears all state in one edge. Operation resumes the next cycle.
- `inst_o` and `data_o` have no reset value; they follow the combinational rules above.

## Test plan
- Store/load: store 0xDEADBEEF @0x100; load 0x100 in the same cycle returns the old value, next cycle returns 0xDEADBEEF. STORES=1; LOADS counts only the aligned RAM loads of 0x100.
- Fetch: `inst_ce_i = 0` gives `inst_o` = 0x00000013. Preload `ram[3]` = 0x00A00093 and fetch @0x0C returns it. A store to `(1<<(DEPTH_BITS+2)) + 0x0C` overwrites the same word (aliasing).
- Misalign: store @0x102 → RAM unchanged, `misalign_o` = 1 next cycle and stays 1 until reset; load @0x101 returns 0.
- MMIO: CYCLE read after 10 post-reset cycles returns 9. Write 0 to TOHOST → `tohost_o` = 0, no halt. Write 7 to TOHOST → `tohost_o` = 7 and `halt_o` = 1 next cycle.
- Post-halt: a store @0x100 is dropped; CYCLE is frozen on repeated reads; a load @0x100 still returns the RAM value.
- Reset: `rst` high for one cycle with a store @0x200 pending → store dropped, all counters and flags 0, RAM @0x100 retained.
